// File: rtl/wc_tile_loader.sv
// wc_tile_loader
//   Host-side transmitter for the Winograd F(2x2,3x3) core's D word stream.
//   It accepts 4x4 tiles into a two-slot ping-pong buffer and 3x3 kernels
//   into a single pending register. Each buffered tile is sent as one frame:
//   a header {1, KLOAD, seq[7:0]}, then 9 kernel words when a new kernel is
//   pending, then 16 pixel words, then GAP idle words of zero.
//
// Ports
//   clk         : rising-edge clock
//   rst         : asynchronous, active-low reset
//   k_valid     : kernel offer
//   k_ready     : pending-kernel register free
//   k_data      : 9 kernel words, word i at [W*i +: W], row-major
//   tile_valid  : tile offer
//   tile_ready  : at least one tile slot free
//   tile_data   : 16 tile words, word i at [W*i +: W], row-major
//   D           : registered stream word to the core
//   busy        : frame in progress (HDR, KERN, PIX, GAP)
//   frame_done  : one-cycle pulse while the last pixel word is on D
//   seq         : sequence number of the current or most recent header
//
// W must be at least 10: the header uses the two top bits as marker and
// KLOAD, and the low 8 bits as the sequence number.
module wc_tile_loader #(
  parameter int W   = 10,
  parameter int GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              k_valid,
  output logic              k_ready,
  input  logic [9*W-1:0]    k_data,
  input  logic              tile_valid,
  output logic              tile_ready,
  input  logic [16*W-1:0]   tile_data,
  output logic [W-1:0]      D,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        seq
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_KERN,
    ST_PIX,
    ST_GAP
  } state_t;

  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  // Control state (reset)
  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n, cnt_inc;
  logic [1:0]  slot_full;
  logic        wr_ptr, rd_ptr;
  logic        kpend, kseen, kload;
  logic [7:0]  next_seq;

  // Datapath storage (not reset; only ever read under valid control state)
  logic [16*W-1:0] slot_mem [2];
  logic [9*W-1:0]  kreg;
  logic [9*W-1:0]  kx;

  // Word views of the slot being drained and of the kernel being sent
  logic [W-1:0] pix_w [16];
  logic [W-1:0] kx_w  [9];

  // Next-cycle outputs / events
  logic [W-1:0] d_n;
  logic         fd_n;
  logic         hdr_go;
  logic         slot_free;
  logic         k_acc, t_acc;

  for (genvar g = 0; g < 16; g++) begin : g_pix
    assign pix_w[g] = slot_mem[rd_ptr][W*g +: W];
  end
  for (genvar g = 0; g < 9; g++) begin : g_kx
    assign kx_w[g] = kx[W*g +: W];
  end

  function automatic logic [W-1:0] hdr_word(input logic kl, input logic [7:0] s);
    logic [W-1:0] h;
    h        = '0;
    h[W-1]   = 1'b1;
    h[W-2]   = kl;
    h[7:0]   = s;
    return h;
  endfunction

  // Ready flags depend only on registered state, never on the valids.
  assign k_ready    = !kpend;
  assign tile_ready = !(&slot_full);
  assign busy       = (state != ST_IDLE);
  assign k_acc      = k_valid && k_ready;
  assign t_acc      = tile_valid && tile_ready;

  // Next-state and next-word logic. D is registered, so each branch selects
  // the word that will be on D after the coming edge.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    d_n       = '0;
    fd_n      = 1'b0;
    hdr_go    = 1'b0;
    slot_free = 1'b0;
    cnt_inc   = cnt + 4'd1;
    case (state)
      ST_IDLE: begin
        if (slot_full[rd_ptr] && kseen) hdr_go = 1'b1;
      end
      ST_HDR: begin
        cnt_n = 4'd0;
        if (kload) begin
          state_n = ST_KERN;
          d_n     = kx_w[0];
        end else begin
          state_n = ST_PIX;
          d_n     = pix_w[0];
        end
      end
      ST_KERN: begin
        if (cnt == 4'd8) begin
          state_n = ST_PIX;
          cnt_n   = 4'd0;
          d_n     = pix_w[0];
        end else begin
          cnt_n = cnt_inc;
          d_n   = kx_w[cnt_inc];
        end
      end
      ST_PIX: begin
        if (cnt == 4'd15) begin
          // Last pixel is on D now; release the slot at this edge.
          slot_free = 1'b1;
          cnt_n     = 4'd0;
          if (GAP > 0)                 state_n = ST_GAP;
          else if (slot_full[~rd_ptr]) hdr_go  = 1'b1;
          else                         state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_inc;
          d_n   = pix_w[cnt_inc];
          fd_n  = (cnt_inc == 4'd15);
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          // rd_ptr already points at the next slot here.
          if (slot_full[rd_ptr]) hdr_go  = 1'b1;
          else                   state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (hdr_go) begin
      state_n = ST_HDR;
      cnt_n   = 4'd0;
      d_n     = hdr_word(kpend, next_seq);
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      D          <= '0;
      frame_done <= 1'b0;
      slot_full  <= 2'b00;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      kpend      <= 1'b0;
      kseen      <= 1'b0;
      kload      <= 1'b0;
      next_seq   <= 8'd0;
      seq        <= 8'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      D          <= d_n;
      frame_done <= fd_n;
      // An accept always targets the free slot and a release the full one,
      // so the two updates never hit the same flag.
      if (t_acc) begin
        slot_full[wr_ptr] <= 1'b1;
        wr_ptr            <= ~wr_ptr;
      end
      if (slot_free) begin
        slot_full[rd_ptr] <= 1'b0;
        rd_ptr            <= ~rd_ptr;
      end
      if (hdr_go) begin
        kload    <= kpend;
        seq      <= next_seq;
        next_seq <= next_seq + 8'd1;
      end
      // k_acc needs kpend=0 and the clear needs kpend=1: mutually exclusive.
      if (hdr_go && kpend) kpend <= 1'b0;
      if (k_acc) begin
        kpend <= 1'b1;
        kseen <= 1'b1;
      end
    end
  end

  // Data registers. The kernel is copied into kx when its header goes out,
  // so a new kernel accepted during that frame cannot disturb it.
  always_ff @(posedge clk) begin
    if (t_acc)          slot_mem[wr_ptr] <= tile_data;
    if (k_acc)          kreg             <= k_data;
    if (hdr_go && kpend) kx              <= kreg;
  end

endmodule

// File: tb/tb_wc_tile_loader.sv
// Directed bench for wc_tile_loader (W=10, GAP=2).
module tb_wc_tile_loader;
  localparam int W   = 10;
  localparam int GAP = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              k_valid;
  logic              k_ready;
  logic [9*W-1:0]    k_data;
  logic              tile_valid;
  logic              tile_ready;
  logic [16*W-1:0]   tile_data;
  logic [W-1:0]      D;
  logic              busy;
  logic              frame_done;
  logic [7:0]        seq;

  wc_tile_loader #(.W(W), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .k_valid    (k_valid),
    .k_ready    (k_ready),
    .k_data     (k_data),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_data  (tile_data),
    .D          (D),
    .busy       (busy),
    .frame_done (frame_done),
    .seq        (seq)
  );

  always #5 clk = ~clk;

  // Edge counter and per-edge output log (sampled on the falling edge).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] dlog  [8192];
  logic         fdlog [8192];
  logic [7:0]   slog  [8192];
  logic         blog  [8192];
  always @(negedge clk) begin
    dlog[cyc[12:0]]  = D;
    fdlog[cyc[12:0]] = frame_done;
    slog[cyc[12:0]]  = seq;
    blog[cyc[12:0]]  = busy;
  end

  function automatic logic [W-1:0] dl(input int n);
    return dlog[n[12:0]];
  endfunction
  function automatic logic fl(input int n);
    return fdlog[n[12:0]];
  endfunction
  function automatic logic [7:0] sl(input int n);
    return slog[n[12:0]];
  endfunction
  function automatic logic bl(input int n);
    return blog[n[12:0]];
  endfunction

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 20000) begin
      step();
      guard++;
    end
  endtask

  task automatic send_tile(input int base, output int t_edge);
    logic hs;
    for (int i = 0; i < 16; i++) tile_data[W*i +: W] = W'(base + i);
    tile_valid = 1'b1;
    t_edge     = -1;
    for (int k = 0; k < 400; k++) begin
      hs = tile_ready;
      step();
      if (hs) begin
        t_edge = cyc;
        break;
      end
    end
    tile_valid = 1'b0;
    chk("tile_accepted", 32'(t_edge >= 0), 32'd1);
  endtask

  task automatic send_kernel(input int base, output int k_edge);
    logic hs;
    for (int i = 0; i < 9; i++) k_data[W*i +: W] = W'(base + i);
    k_valid = 1'b1;
    k_edge  = -1;
    for (int k = 0; k < 400; k++) begin
      hs = k_ready;
      step();
      if (hs) begin
        k_edge = cyc;
        break;
      end
    end
    k_valid = 1'b0;
    chk("kernel_accepted", 32'(k_edge >= 0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tk, tt, a, a2, a3, x, b, kb, b2, c, e, e2, f, t, tmp;
    logic nz;

    rst        = 1'b0;
    k_valid    = 1'b0;
    tile_valid = 1'b0;
    k_data     = '0;
    tile_data  = '0;

    // Reset values
    repeat (3) step();
    chk("rst_D",          32'(D),          32'h0);
    chk("rst_k_ready",    32'(k_ready),    32'h1);
    chk("rst_tile_ready", 32'(tile_ready), 32'h1);
    chk("rst_busy",       32'(busy),       32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_seq",        32'(seq),        32'h0);
    rst = 1'b1;
    step();
    step();

    // Kernel 1..9 then tile 16..31
    send_kernel(1, tk);
    chk("kpend_blocks_k_ready", 32'(k_ready), 32'h0);
    step();
    step();
    chk("no_tile_not_busy", 32'(busy), 32'h0);
    send_tile(16, tt);
    wait_until(tt + 32);
    chk("t1_header", 32'(dl(tt + 1)), 32'h300);
    chk("t1_seq",    32'(sl(tt + 1)), 32'h0);
    for (int i = 0; i < 9; i++)  chk("t1_kernel_word", 32'(dl(tt + 2 + i)), 32'(1 + i));
    for (int i = 0; i < 16; i++) chk("t1_pixel_word", 32'(dl(tt + 11 + i)), 32'(16 + i));
    chk("t1_gap0", 32'(dl(tt + 27)), 32'h0);
    chk("t1_gap1", 32'(dl(tt + 28)), 32'h0);
    chk("t1_fd_before", 32'(fl(tt + 25)), 32'h0);
    chk("t1_fd_last",   32'(fl(tt + 26)), 32'h1);
    chk("t1_fd_after",  32'(fl(tt + 27)), 32'h0);
    chk("t1_k_ready_after", 32'(k_ready), 32'h1);

    // Three tiles offered back to back, no kernel reload
    send_tile(100, a);
    chk("t3_ready_one_full", 32'(tile_ready), 32'h1);
    send_tile(200, a2);
    chk("t3_second_accept", 32'(a2), 32'(a + 1));
    chk("t3_ready_both_full", 32'(tile_ready), 32'h0);
    send_tile(300, a3);
    chk("t3_third_accept", 32'(a3), 32'(a + 19));
    wait_until(a + 62);
    chk("t3_hdr1",     32'(dl(a + 1)),  32'h201);
    chk("t3_f1_pix0",  32'(dl(a + 2)),  32'd100);
    chk("t3_f1_pix15", 32'(dl(a + 17)), 32'd115);
    chk("t3_f1_fd",    32'(fl(a + 17)), 32'h1);
    chk("t3_gap0",     32'(dl(a + 18)), 32'h0);
    chk("t3_gap1",     32'(dl(a + 19)), 32'h0);
    chk("t3_hdr2",     32'(dl(a + 20)), 32'h202);
    chk("t3_hdr2_seq", 32'(sl(a + 20)), 32'h2);
    chk("t3_f2_pix0",  32'(dl(a + 21)), 32'd200);
    chk("t3_hdr3",     32'(dl(a + 39)), 32'h203);
    chk("t3_f3_pix0",  32'(dl(a + 40)), 32'd300);

    // Frame 4, then kernel arrives during PIX of frame 5
    send_tile(500, x);
    wait_until(x + 22);
    send_tile(600, b);
    wait_until(b + 5);
    send_kernel(700, kb);
    chk("t4_kernel_in_pix", 32'(kb), 32'(b + 6));
    send_tile(800, b2);
    wait_until(b + 52);
    chk("t4_hdr5",     32'(dl(b + 1)),  32'h205);
    chk("t4_f5_pix0",  32'(dl(b + 2)),  32'd600);
    chk("t4_f5_pix15", 32'(dl(b + 17)), 32'd615);
    chk("t4_f5_fd",    32'(fl(b + 17)), 32'h1);
    chk("t4_hdr6",     32'(dl(b + 20)), 32'h306);
    chk("t4_hdr6_seq", 32'(sl(b + 20)), 32'h6);
    chk("t4_f6_k0",    32'(dl(b + 21)), 32'd700);
    chk("t4_f6_k8",    32'(dl(b + 29)), 32'd708);
    chk("t4_f6_pix0",  32'(dl(b + 30)), 32'd800);
    chk("t4_f6_pix15", 32'(dl(b + 45)), 32'd815);

    // Frames 7..255, then frame 256 wraps seq to 0
    for (int i = 0; i < 249; i++) send_tile(i * 3, tmp);
    wait_until(cyc + 40);
    chk("t5_seq_255",   32'(seq),  32'hFF);
    chk("t5_idle",      32'(busy), 32'h0);
    send_tile(5, c);
    wait_until(c + 25);
    chk("t5_hdr_wrap",  32'(dl(c + 1)), 32'h200);
    chk("t5_seq_wrap",  32'(sl(c + 1)), 32'h0);
    chk("t5_pix0",      32'(dl(c + 2)), 32'd5);

    // Reset at pixel word 8, with a second tile buffered
    send_tile(900, e);
    send_tile(950, e2);
    wait_until(e + 10);
    chk("t6_pix8", 32'(D), 32'd908);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_async_D",      32'(D),          32'h0);
    chk("t6_busy",         32'(busy),       32'h0);
    chk("t6_fd",           32'(frame_done), 32'h0);
    chk("t6_seq",          32'(seq),        32'h0);
    chk("t6_k_ready",      32'(k_ready),    32'h1);
    chk("t6_tile_ready",   32'(tile_ready), 32'h1);
    #2;
    rst = 1'b1;
    step();
    send_tile(100, f);
    wait_until(f + 31);
    nz = 1'b0;
    for (int i = 1; i <= 30; i++) nz = nz | (|dl(f + i)) | bl(f + i);
    chk("t6_held_no_frame", 32'(nz), 32'h0);
    chk("t6_old_tiles_discarded", 32'(tile_ready), 32'h1);
    send_kernel(20, t);
    wait_until(t + 32);
    chk("t6_hdr",     32'(dl(t + 1)),  32'h300);
    chk("t6_hdr_seq", 32'(sl(t + 1)),  32'h0);
    chk("t6_k0",      32'(dl(t + 2)),  32'd20);
    chk("t6_pix0",    32'(dl(t + 11)), 32'd100);
    chk("t6_no_second_frame_busy", 32'(busy), 32'h0);
    chk("t6_no_second_frame_D",    32'(D),    32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wc_tile_loader.md
# wc_tile_loader

Host-side transmitter for the Winograd F(2x2,3x3) core's 10-bit `D` input stream. It accepts 4x4 input tiles and 3x3 kernels on parallel valid/ready ports and double-buffers the tiles. Each tile is serialised into a framed word stream: a header, optional kernel words, then pixel words. The block sits in the test/host harness in front of the chip's `D` pads and is the sending end of the protocol the core decodes.

## Interface
- `W`, default 10: word width; equals the `D` bus width.
- `GAP`, default 2: number of idle words (0) driven after every frame, range 0..15.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `k_valid`  in  1: kernel offer.
- `k_ready`  out  1: kernel register free.
- `k_data`  in  9*W: kernel; word i = `k_data[W*i +: W]`, row-major.
- `tile_valid`  in  1: tile offer.
- `tile_ready`  out  1: at least one tile slot is free.
- `tile_data`  in  16*W: tile; word i = `tile_data[W*i +: W]`, row-major.
- `D`  out  W: registered stream word to the core.
- `busy`  out  1: high in states HDR, KERN, PIX and GAP.
- `frame_done`  out  1: one-cycle pulse in the cycle the last pixel word is on `D`.
- `seq`  out  8: sequence number of the current or most recent frame header.

## Operation
- Frame format, all words on consecutive cycles:
  - Header: `{1'b1, KLOAD, seq[7:0]}`.
  - Kernel: 9 words, present only if KLOAD=1.
  - Pixels: 16 words.
  - Frame length is 26 words with kernel, 17 without, followed by `GAP` idle words of 10'h000.
- Idle words always have bit9=0. The core detects a header only between frames, so data words are unrestricted.
- Handshakes transfer on `valid && ready` at a rising edge.
  - `valid` must hold with data stable until accepted.
  - `ready` is a registered function of internal state only; there is no combinational path from `valid`.
- Tile buffer:
  - Two slots (ping-pong), drained in FIFO order.
  - `tile_ready`=0 only when both slots are full.
  - A slot frees in the cycle after `frame_done`.
- Kernel register:
  - One pending kernel plus a `kpend` flag.
  - `k_ready` = !kpend.
  - An accepted kernel sets `kpend`. The next frame header carries KLOAD=1 and transmits that kernel, and `kpend` clears when that header is driven.
  - A kernel accepted mid-frame applies to the following frame, never to the current one.
- `kseen` flag: set by the first kernel accept after reset. No frame starts while `kseen`=0; tiles are buffered but held.
- FSM states:
  - IDLE to HDR when a slot is full and `kseen`=1.
  - HDR to KERN if KLOAD, else to PIX.
  - KERN (9 cycles) to PIX.
  - PIX (16 cycles) to GAP if `GAP`>0.
  - At the end of PIX with `GAP`=0, or at the end of GAP: go to HDR if the next slot is full, else to IDLE.
- `seq`:
  - The first header after reset carries 0.
  - Increments by 1 after each header and wraps 255 to 0.
  - The `seq` output updates in the cycle its header is driven.

## Timing
- Reset values: `D`=0, `k_ready`=1, `tile_ready`=1, `busy`=0, `frame_done`=0, `seq`=0. Slots are empty, `kpend`=0, `kseen`=0, state is IDLE.
- Reset mid-frame:
  - `D` goes to 0 immediately (asynchronously).
  - The partial frame is abandoned.
  - All buffered tiles and the pending kernel are discarded.
- Latency: a tile accepted at edge t while IDLE with `kseen`=1 puts its header on `D` at edge t+1.
- Back-to-back frames: the next header is driven exactly `GAP` cycles after the last pixel word, with no extra bubble.
- Simultaneous events:
  - A tile accept and a slot free in the same cycle are both honoured.
  - A kernel accept in the same cycle that a header with KLOAD=1 is driven is legal. The old kernel goes out with this frame and the new one with the next.
- Throughput with `GAP`=2 and no kernel reload is one tile per 19 cycles.

## Test plan
- Reset, then a kernel with words 1..9, then a tile with words 16..31.
  - `D` sequence: 10'h300, 1..9, 16..31, 0, 0.
  - `frame_done` pulses with word 31.
- Tile offered before any kernel: it is held (`busy`=0). A kernel is then accepted at edge t, and the header 10'h300 appears at edge t+1.
- Three tiles offered continuously with no kernel reload:
  - `tile_ready` drops after 2 accepts.
  - Headers 10'h201 and 10'h202 are spaced exactly 19 cycles apart.
- Kernel accepted during the PIX state of frame seq=5: frame 5 is unchanged, and frame 6's header is 10'h306 with the new kernel words.
- Send 256 frames: `seq` wraps, and frame 256's header carries seq=0.
- Assert `rst` low at pixel word 8: `D`=0 asynchronously. After release, a new tile alone produces no frame until a kernel is accepted.
